// File: rtl/hyperbus_tf_splitter.sv
// hyperbus_tf_splitter: breaks long linear HyperBus transfers into
// sub-transfers of at most cfg_t_burst_max_i words (t_CSM limit).
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cfg_t_burst_max_i       max words per chunk (0 = no split)
//   cfg_address_mask_msb_i  highest incrementing address bit
//   tf_*_i / tf_ready_o     parent descriptor, valid/ready handshake
//   tf_*_o / tf_ready_i     chunk descriptor, valid/ready handshake
//   tf_last_o               chunk is the final one of its parent
//   chunk_cnt_o             emitted-chunk counter
//
// Optional: define HYPERBUS_SPLIT_STATS_EN to build the saturating
// chunk counter; otherwise chunk_cnt_o is tied to 0.

module hyperbus_tf_splitter #(
  parameter int BurstWidth = 15,
  parameter int AddrWidth  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [15:0]           cfg_t_burst_max_i,
  input  logic [4:0]            cfg_address_mask_msb_i,
  input  logic                  tf_valid_i,
  output logic                  tf_ready_o,
  input  logic                  tf_write_i,
  input  logic [BurstWidth-1:0] tf_burst_i,
  input  logic                  tf_burst_type_i,
  input  logic                  tf_address_space_i,
  input  logic [AddrWidth-1:0]  tf_address_i,
  output logic                  tf_valid_o,
  input  logic                  tf_ready_i,
  output logic                  tf_write_o,
  output logic [BurstWidth-1:0] tf_burst_o,
  output logic                  tf_burst_type_o,
  output logic                  tf_address_space_o,
  output logic [AddrWidth-1:0]  tf_address_o,
  output logic                  tf_last_o,
  output logic [15:0]           chunk_cnt_o
);

  typedef enum logic {
    Idle,
    Emit
  } state_e;

  state_e state_q, state_d;

  logic                  write_q;
  logic                  btype_q;
  logic                  space_q;
  logic [AddrWidth-1:0]  addr_q;
  logic [BurstWidth-1:0] rem_q;
  logic [15:0]           limit_q;
  logic [4:0]            msb_q;

  logic                  split;
  logic [BurstWidth-1:0] chunk;
  logic [AddrWidth-1:0]  mask;
  logic [AddrWidth-1:0]  sum;
  logic [AddrWidth-1:0]  addr_d;
  logic                  accept;
  logic                  hs;

  // 32-bit compare: a limit of 2^15 or more never splits.
  assign split = (limit_q != 16'd0) & btype_q & ~space_q
               & (32'(rem_q) > 32'(limit_q));

  assign chunk = split ? limit_q[BurstWidth-1:0] : rem_q;

  always_comb begin
    mask = '0;
    for (int i = 0; i < AddrWidth; i++) begin
      mask[i] = (i <= int'(msb_q));
    end
  end

  // Low bits wrap inside the mask window, high bits are held.
  assign sum    = addr_q + AddrWidth'({chunk, 1'b0});
  assign addr_d = (sum & mask) | (addr_q & ~mask);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tf_ready_o = 1'b0;
    tf_valid_o = 1'b0;
    unique case (state_q)
      Idle: begin
        tf_ready_o = 1'b1;
        if (tf_valid_i) state_d = Emit;
      end
      Emit: begin
        tf_valid_o = 1'b1;
        if (tf_ready_i && !split) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  assign accept = tf_valid_i & tf_ready_o;
  assign hs     = tf_valid_o & tf_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      write_q <= 1'b0;
      btype_q <= 1'b0;
      space_q <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      limit_q <= '0;
      msb_q   <= '0;
    end else if (accept) begin
      write_q <= tf_write_i;
      btype_q <= tf_burst_type_i;
      space_q <= tf_address_space_i;
      addr_q  <= tf_address_i & ~AddrWidth'(1);
      rem_q   <= tf_burst_i;
      limit_q <= cfg_t_burst_max_i;
      msb_q   <= cfg_address_mask_msb_i;
    end else if (hs && split) begin
      rem_q  <= rem_q - chunk;
      addr_q <= addr_d;
    end
  end

  assign tf_write_o         = write_q;
  assign tf_burst_o         = chunk;
  assign tf_burst_type_o    = btype_q;
  assign tf_address_space_o = space_q;
  assign tf_address_o       = addr_q;
  assign tf_last_o          = tf_valid_o & ~split;

`ifdef HYPERBUS_SPLIT_STATS_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (hs && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign chunk_cnt_o = cnt_q;
`else
  assign chunk_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hyperbus_tf_splitter.sv
// tb_hyperbus_tf_splitter: directed and random parents checked
// against a chunk-list model built from the splitting rules.

module tb_hyperbus_tf_splitter;

  localparam int BW = 15;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   cfg_max = '0;
  logic [4:0]    cfg_msb = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic          write_i = 1'b0;
  logic [BW-1:0] burst_i = '0;
  logic          btype_i = 1'b0;
  logic          space_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic          write_o;
  logic [BW-1:0] burst_o;
  logic          btype_o;
  logic          space_o;
  logic [AW-1:0] addr_o;
  logic          last_o;
  logic [15:0]   cnt_o;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  hyperbus_tf_splitter #(.BurstWidth(BW), .AddrWidth(AW)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .cfg_t_burst_max_i      (cfg_max),
    .cfg_address_mask_msb_i (cfg_msb),
    .tf_valid_i             (valid_i),
    .tf_ready_o             (ready_o),
    .tf_write_i             (write_i),
    .tf_burst_i             (burst_i),
    .tf_burst_type_i        (btype_i),
    .tf_address_space_i     (space_i),
    .tf_address_i           (addr_i),
    .tf_valid_o             (valid_o),
    .tf_ready_i             (ready_i),
    .tf_write_o             (write_o),
    .tf_burst_o             (burst_o),
    .tf_burst_type_o        (btype_o),
    .tf_address_space_o     (space_o),
    .tf_address_o           (addr_o),
    .tf_last_o              (last_o),
    .chunk_cnt_o            (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic count_chunk();
`ifdef HYPERBUS_SPLIT_STATS_EN
    if (exp_cnt < 65535) exp_cnt++;
`endif
  endtask

  // mode 0: ready always, 1: random stalls, 2: 5 stalls on chunk 1
  task automatic run_parent(input logic w, input int burst,
                            input logic bt, input logic sp,
                            input logic [31:0] addr, input int tmax,
                            input int msb, input int mode);
    int          qb[$];
    logic [31:0] qa[$];
    bit          ql[$];
    int          rem;
    longint      a;
    longint      m;
    longint      lo;
    int          c;
    bit          sp_now;
    int          idx;
    int          stall;
    rem = burst;
    a   = longint'(addr) & 64'hFFFF_FFFE;
    m   = longint'(1) << (msb + 1);
    idx = 0;
    forever begin
      sp_now = (tmax != 0) && bt && !sp && (rem > tmax);
      c = sp_now ? tmax : rem;
      qb.push_back(c);
      qa.push_back(a[31:0]);
      ql.push_back(!sp_now);
      if (!sp_now) break;
      rem -= c;
      lo = ((a % m) + 2 * c) % m;
      a  = a - (a % m) + lo;
    end

    check("ready_idle", ready_o, 1);
    write_i = w;
    burst_i = BW'(burst);
    btype_i = bt;
    space_i = sp;
    addr_i  = addr;
    cfg_max = 16'(tmax);
    cfg_msb = 5'(msb);
    valid_i = 1'b1;
    ready_i = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    write_i = ~w;
    burst_i = BW'($urandom);
    btype_i = 1'($urandom);
    space_i = 1'($urandom);
    addr_i  = $urandom;
    cfg_max = 16'($urandom);
    cfg_msb = 5'($urandom);

    while (qb.size() > 0) begin
      if (mode == 2) stall = (idx == 1) ? 5 : 0;
      else if (mode == 1) stall = $urandom_range(0, 3);
      else stall = 0;
      for (int s = stall; s >= 0; s--) begin
        check("valid_o", valid_o, 1);
        check("ready_busy", ready_o, 0);
        check("burst_o", burst_o, qb[0]);
        check("addr_o", addr_o, qa[0]);
        check("last_o", last_o, ql[0]);
        check("write_o", write_o, w);
        check("btype_o", btype_o, bt);
        check("space_o", space_o, sp);
        ready_i = (s == 0);
        @(negedge clk);
      end
      void'(qb.pop_front());
      void'(qa.pop_front());
      void'(ql.pop_front());
      count_chunk();
      idx++;
    end
    check("valid_end", valid_o, 0);
    check("ready_end", ready_o, 1);
    check("chunk_cnt", cnt_o, exp_cnt);
  endtask

  initial begin
    int bl;
    int tm;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_last", last_o, 0);
    check("rst_burst", burst_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_write", write_o, 0);
    check("rst_cnt", cnt_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // split, no-split cases, zero burst, huge limit
    run_parent(1, 250, 1, 0, 32'h0000_1000, 100, 25, 0);
    run_parent(0, 300, 1, 0, 32'h0000_2000, 0, 25, 0);
    run_parent(1, 64, 0, 0, 32'h0000_3000, 16, 25, 0);
    run_parent(0, 1, 1, 1, 32'h0000_0041, 16, 25, 0);
    run_parent(0, 0, 1, 0, 32'h0000_4000, 8, 25, 0);
    run_parent(1, 20000, 1, 0, 32'h0000_5000, 32768, 31, 0);
    // backpressure on chunk 2
    run_parent(1, 250, 1, 0, 32'h0000_1000, 100, 25, 2);
    // address wrap inside the mask window
    run_parent(0, 32, 1, 0, 32'hABCD_0FF0, 8, 11, 0);

    // reset in the middle of a 3-chunk parent
    check("ready_pre", ready_o, 1);
    write_i = 1'b1;
    burst_i = BW'(250);
    btype_i = 1'b1;
    space_i = 1'b0;
    addr_i  = 32'h0000_1000;
    cfg_max = 16'd100;
    cfg_msb = 5'd25;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    check("mid_valid", valid_o, 1);
    check("mid_burst", burst_o, 100);
    ready_i = 1'b1;
    @(negedge clk);
    check("mid_addr2", addr_o, 32'h0000_10C8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    check("rst_mid_valid", valid_o, 0);
    check("rst_mid_ready", ready_o, 1);
    check("rst_mid_last", last_o, 0);
    check("rst_mid_cnt", cnt_o, 0);
    run_parent(0, 4, 1, 0, 32'h0000_0100, 100, 25, 0);

    // stats: 3 + 1 + 1 chunks after reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    run_parent(1, 250, 1, 0, 32'h0000_1000, 100, 25, 1);
    run_parent(0, 300, 1, 0, 32'h0000_2000, 0, 25, 1);
    run_parent(1, 64, 0, 0, 32'h0000_3000, 16, 25, 1);
`ifdef HYPERBUS_SPLIT_STATS_EN
    check("stats_5", cnt_o, 5);
`else
    check("stats_0", cnt_o, 0);
`endif

    for (int i = 0; i < 30; i++) begin
      bl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 300);
      case ($urandom_range(0, 3))
        0: tm = 0;
        1: tm = $urandom_range(1, 40);
        2: tm = $urandom_range(41, 400);
        default: tm = $urandom_range(32768, 65535);
      endcase
      run_parent(1'($urandom), bl,
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0),
                 $urandom, tm, $urandom_range(0, 31), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
